// File: rtl/combination_counter.sv
// Exact-match combination counter: LANE bitsets per cycle against NUM_FILTERS
// masks, saturating counters, atomic capture-and-clear into a readable bank.
module combination_counter #(
  parameter int LANE        = 4,
  parameter int COMB_WIDTH  = 16,
  parameter int NUM_FILTERS = 8,
  parameter int CNT_WIDTH   = 32,
  localparam int AW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COMB_WIDTH-1:0] in_bitset [LANE],
  input  logic [LANE-1:0]       in_valid,
  input  logic [COMB_WIDTH-1:0] filter_mask [NUM_FILTERS],
  input  logic                  capture,
  output logic                  capture_done,
  input  logic                  rd_req,
  input  logic [AW-1:0]         rd_addr,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic                  rd_overflow,
  output logic                  rd_valid
);

  localparam int IW = $clog2(LANE + 1);

  logic [LANE-1:0]      match_d [NUM_FILTERS];
  logic [LANE-1:0]      match_q [NUM_FILTERS];
  logic [IW-1:0]        inc_d   [NUM_FILTERS];
  logic [IW-1:0]        inc_q   [NUM_FILTERS];
  logic [CNT_WIDTH:0]   wide_d  [NUM_FILTERS];
  logic [CNT_WIDTH-1:0] sat_d   [NUM_FILTERS];
  logic [CNT_WIDTH-1:0] cnt_q   [NUM_FILTERS];
  logic [CNT_WIDTH-1:0] snap_q  [NUM_FILTERS];
  logic [NUM_FILTERS-1:0] carry_d;
  logic [NUM_FILTERS-1:0] ovf_q;
  logic [NUM_FILTERS-1:0] snap_ovf_q;

  logic cap1_q;
  logic cap2_q;
  logic done_q;

  logic [CNT_WIDTH-1:0] rd_sel;
  logic                 rd_sel_ovf;
  logic [CNT_WIDTH-1:0] rd_data_q;
  logic                 rd_ovf_q;
  logic                 rd_valid_q;

  // A zero mask is disabled rather than matching empty bitsets
  always_comb begin
    for (int f = 0; f < NUM_FILTERS; f++) begin
      match_d[f] = '0;
      for (int i = 0; i < LANE; i++) begin
        match_d[f][i] = in_valid[i]
                     && (filter_mask[f] != '0)
                     && (in_bitset[i] == filter_mask[f]);
      end
    end
  end

  always_comb begin
    for (int f = 0; f < NUM_FILTERS; f++) begin
      inc_d[f] = '0;
      for (int i = 0; i < LANE; i++) begin
        inc_d[f] = inc_d[f] + IW'(match_q[f][i]);
      end
    end
  end

  always_comb begin
    carry_d = '0;
    for (int f = 0; f < NUM_FILTERS; f++) begin
      wide_d[f] = {1'b0, cnt_q[f]} + (CNT_WIDTH+1)'(inc_q[f]);
      carry_d[f] = wide_d[f][CNT_WIDTH];
      sat_d[f] = carry_d[f] ? '1 : wide_d[f][CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < NUM_FILTERS; f++) begin
        match_q[f] <= '0;
        inc_q[f]   <= '0;
      end
      cap1_q <= 1'b0;
      cap2_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      for (int f = 0; f < NUM_FILTERS; f++) begin
        match_q[f] <= match_d[f];
        inc_q[f]   <= inc_d[f];
      end
      cap1_q <= capture;
      cap2_q <= cap1_q;
      done_q <= cap2_q;
    end
  end

  // Capture folds the final increment into the snapshot, then restarts at 0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < NUM_FILTERS; f++) begin
        cnt_q[f]  <= '0;
        snap_q[f] <= '0;
      end
      ovf_q      <= '0;
      snap_ovf_q <= '0;
    end else begin
      for (int f = 0; f < NUM_FILTERS; f++) begin
        if (cap2_q) begin
          snap_q[f]     <= sat_d[f];
          snap_ovf_q[f] <= ovf_q[f] | carry_d[f];
          cnt_q[f]      <= '0;
          ovf_q[f]      <= 1'b0;
        end else begin
          cnt_q[f] <= sat_d[f];
          ovf_q[f] <= ovf_q[f] | carry_d[f];
        end
      end
    end
  end

  always_comb begin
    rd_sel     = '0;
    rd_sel_ovf = 1'b0;
    for (int f = 0; f < NUM_FILTERS; f++) begin
      if (rd_addr == AW'(f)) begin
        rd_sel     = snap_q[f];
        rd_sel_ovf = snap_ovf_q[f];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_ovf_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req) begin
        rd_data_q <= rd_sel;
        rd_ovf_q  <= rd_sel_ovf;
      end
    end
  end

  assign capture_done = done_q;
  assign rd_data      = rd_data_q;
  assign rd_overflow  = rd_ovf_q;
  assign rd_valid     = rd_valid_q;

endmodule
